pixel_frame_streamer: RTL and testbench



---
 rtl/pixel_frame_streamer_if.sv | 26 ++
 rtl/pixel_frame_streamer.sv | 114 +++++++++++
 tb/tb_pixel_frame_streamer.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_frame_streamer_if.sv
// Host write port plus the CONV1 pixel stream of pixel_frame_streamer.
// master = host/controller side, slave = the streamer.
interface pixel_frame_streamer_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8
);
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_err;
  logic                  start;
  logic                  busy;
  logic [DATA_WIDTH-1:0] pixel_out;
  logic                  valid_out;
  logic                  frame_done;

  modport master (
    output wr_en, wr_addr, wr_data, start,
    input  wr_err, busy, pixel_out, valid_out, frame_done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start,
    output wr_err, busy, pixel_out, valid_out, frame_done
  );
endinterface

// File: rtl/pixel_frame_streamer.sv
// Frame RAM + raster-order transmitter for CONV1; first beat 2 cycles after start, no backpressure.
// Optional macro PIXEL_HALF_EN halves every streamed pixel (right shift by one).
module pixel_frame_streamer #(
  parameter int NUM_PIXELS = 784,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8,
  parameter int PIXEL_GAP  = 0,
  parameter int GAP_WIDTH  = 8
) (
  input logic                   clk,
  input logic                   rst,
  pixel_frame_streamer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, PRIME, STREAM, GAP, DONE} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] mem [NUM_PIXELS];
  logic [DATA_WIDTH-1:0] ram_q;
  logic [DATA_WIDTH-1:0] pixel_next;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH-1:0] idx;
  logic [GAP_WIDTH-1:0]  gap_cnt;
  logic                  addr_ok;
  logic                  wr_ok;
  logic                  rd_en;
  logic                  advance;
  logic                  last_beat;

  assign addr_ok   = {1'b0, bus.wr_addr} < (ADDR_WIDTH+1)'(NUM_PIXELS);
  assign wr_ok     = bus.wr_en && !rst && (state == IDLE) && addr_ok;
  assign last_beat = (idx == ADDR_WIDTH'(NUM_PIXELS - 1));

  // advance = the next cycle is a STREAM beat; the following read is issued alongside it
  assign advance = (state == PRIME)
                || (state == STREAM && !last_beat && PIXEL_GAP == 0)
                || (state == GAP && gap_cnt == GAP_WIDTH'(1));

  assign rd_en = (state == IDLE && bus.start)
              || (advance && ({1'b0, rd_ptr} < (ADDR_WIDTH+1)'(NUM_PIXELS)));

  // Write-first forwarding lets a write coinciding with start land in the first read
  always_ff @(posedge clk) begin
    if (wr_ok)
      mem[bus.wr_addr] <= bus.wr_data;
    if (rd_en)
      ram_q <= (wr_ok && bus.wr_addr == rd_ptr) ? bus.wr_data : mem[rd_ptr];
  end

`ifdef PIXEL_HALF_EN
  assign pixel_next = {1'b0, ram_q[DATA_WIDTH-1:1]};
`else
  assign pixel_next = ram_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      bus.busy       <= 1'b0;
      bus.valid_out  <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.wr_err     <= 1'b0;
      bus.pixel_out  <= '0;
      rd_ptr         <= '0;
      gap_cnt        <= '0;
      idx            <= '0;
    end else begin
      bus.wr_err     <= bus.wr_en && !wr_ok;
      bus.frame_done <= 1'b0;
      if (rd_en)
        rd_ptr <= rd_ptr + 1'b1;
      if (advance) begin
        bus.valid_out <= 1'b1;
        bus.pixel_out <= pixel_next;
      end
      case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= PRIME;
            bus.busy <= 1'b1;
            idx      <= '0;
          end
        end
        PRIME: state <= STREAM;
        STREAM: begin
          if (last_beat) begin
            state          <= DONE;
            bus.valid_out  <= 1'b0;
            bus.frame_done <= 1'b1;
          end else if (PIXEL_GAP > 0) begin
            state         <= GAP;
            bus.valid_out <= 1'b0;
            gap_cnt       <= GAP_WIDTH'(PIXEL_GAP);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_WIDTH'(1)) begin
            state <= STREAM;
            idx   <= idx + 1'b1;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
          rd_ptr   <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pixel_frame_streamer.sv
// Runs a back-to-back (gap 0) and a gapped (gap 3) streamer on identical host traffic;
// expected beats are queued at start and checked by a negedge monitor.
`timescale 1ns/1ps
module tb_pixel_frame_streamer;
  localparam int N  = 784;
  localparam int AW = 10;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          start = 1'b0;

  always #5 clk = ~clk;

  pixel_frame_streamer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
  pixel_frame_streamer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();

  assign bus0.wr_en   = wr_en;
  assign bus0.wr_addr = wr_addr;
  assign bus0.wr_data = wr_data;
  assign bus0.start   = start;
  assign bus1.wr_en   = wr_en;
  assign bus1.wr_addr = wr_addr;
  assign bus1.wr_data = wr_data;
  assign bus1.start   = start;

  pixel_frame_streamer #(.NUM_PIXELS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                         .PIXEL_GAP(0), .GAP_WIDTH(8)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0));
  pixel_frame_streamer #(.NUM_PIXELS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                         .PIXEL_GAP(3), .GAP_WIDTH(8)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1));

  logic [1:0]         vo, fd, bz, er;
  logic [1:0][DW-1:0] po;
  assign vo = {bus1.valid_out, bus0.valid_out};
  assign fd = {bus1.frame_done, bus0.frame_done};
  assign bz = {bus1.busy, bus0.busy};
  assign er = {bus1.wr_err, bus0.wr_err};
  assign po[0] = bus0.pixel_out;
  assign po[1] = bus1.pixel_out;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int model [N];
  int q0 [$];
  int q1 [$];
  int exp_first_cyc = -100;
  int bad_wr_cyc    = -100;
  int exp_err       = 0;
  int beats    [2] = '{0, 0};
  int done_cnt [2] = '{0, 0};
  int err_seen [2] = '{0, 0};
  int first_cyc[2] = '{0, 0};
  int prev_cyc [2] = '{0, 0};
  int last_cyc [2] = '{-100, -100};
  bit in_frame [2] = '{0, 0};
  bit busy_chk [2] = '{0, 0};
  bit rst_pend = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d: got %0d expected %0d (cycle %0d)", name, d, act, exp, cyc);
    end
  endtask

  function automatic int gap_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic int exp_px(input int v);
`ifdef PIXEL_HALF_EN
    return v / 2;
`else
    return v;
`endif
  endfunction

  // Monitor: checks every presented beat, frame_done and wr_err against the queued expectations
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int e, qs;
      if (rst_pend) begin
        chk("rst_valid", d, vo[d], 0);
        chk("rst_busy", d, bz[d], 0);
      end
      if (busy_chk[d]) begin
        chk("busy_fall", d, bz[d], 0);
        busy_chk[d] = 1'b0;
      end
      if (vo[d] === 1'b1) begin
        qs = (d == 0) ? q0.size() : q1.size();
        chk("beat_expected", d, qs > 0, 1);
        if (qs > 0) begin
          e = (d == 0) ? q0.pop_front() : q1.pop_front();
          chk("pixel", d, po[d], e);
          if (!in_frame[d]) begin
            chk("first_latency", d, cyc, exp_first_cyc);
            in_frame[d]  = 1'b1;
            first_cyc[d] = cyc;
          end else begin
            chk("beat_spacing", d, cyc - prev_cyc[d], gap_of(d) + 1);
          end
          prev_cyc[d] = cyc;
          beats[d]++;
          if (qs == 1) begin
            chk("frame_length", d, cyc - first_cyc[d], (N - 1) * (gap_of(d) + 1));
            last_cyc[d] = cyc;
          end
        end
      end
      if (fd[d] === 1'b1) begin
        chk("done_timing", d, cyc, last_cyc[d] + 1);
        chk("busy_in_done", d, bz[d], 1);
        done_cnt[d]++;
        in_frame[d] = 1'b0;
        last_cyc[d] = -100;
        busy_chk[d] = 1'b1;
      end
      if (er[d] === 1'b1) begin
        chk("err_timing", d, cyc, bad_wr_cyc + 1);
        err_seen[d]++;
      end
    end
    rst_pend = 1'b0;
    if (rst) begin
      q0.delete();
      q1.delete();
      for (int d = 0; d < 2; d++) begin
        in_frame[d] = 1'b0;
        last_cyc[d] = -100;
        busy_chk[d] = 1'b0;
      end
      rst_pend = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_px(input int a, input int v, input bit rejected);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = DW'(v);
    if (rejected) begin
      bad_wr_cyc = cyc;
      exp_err++;
    end
    tick();
    wr_en = 1'b0;
  endtask

  task automatic load_frame();
    for (int i = 0; i < N; i++) write_px(i, model[i], 1'b0);
  endtask

  task automatic start_frame(input bit with_wr0, input int v0);
    if (with_wr0) begin
      wr_en    = 1'b1;
      wr_addr  = '0;
      wr_data  = DW'(v0);
      model[0] = v0;
    end
    for (int i = 0; i < N; i++) begin
      q0.push_back(exp_px(model[i]));
      q1.push_back(exp_px(model[i]));
    end
    exp_first_cyc = cyc + 2;
    start = 1'b1;
    tick();
    start = 1'b0;
    wr_en = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while ((done_cnt[0] < target || done_cnt[1] < target) && n < 5000) begin
      tick();
      n++;
    end
    chk("frames_done", 0, done_cnt[0], target);
    chk("frames_done", 1, done_cnt[1], target);
    tick();
    tick();
  endtask

  task automatic wait_beats(input int target);
    int n = 0;
    while (beats[0] < target && n < 4000) begin
      tick();
      n++;
    end
    chk("beat_reached", 0, beats[0], target);
  endtask

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    chk("reset_pixel", 0, bus0.pixel_out, 0);
    chk("reset_pixel", 1, bus1.pixel_out, 0);
    chk("reset_err", 0, bus0.wr_err, 0);
    chk("reset_done", 1, bus1.frame_done, 0);

    // Ramp frame; pixel 0 is rewritten in the start cycle and the new value must stream
    for (int i = 0; i < N; i++) model[i] = i % 128;
    model[0] = 77;
    load_frame();
    start_frame(1'b1, 0);
    wait_done(1);

    // Random frame with the half-scale corner values; start and a write mid-stream are ignored
    for (int i = 0; i < N; i++) model[i] = int'($urandom_range(0, 255));
    model[0] = 255;
    model[1] = 128;
    model[5] = 5;
    load_frame();
    repeat ($urandom_range(1, 5)) tick();
    start_frame(1'b0, 0);
    wait_beats(beats[0] + 10);
    start = 1'b1;
    tick();
    start = 1'b0;
    write_px(5, 99, 1'b1);
    wait_done(2);
    chk("err_count", 0, err_seen[0], exp_err);
    chk("err_count", 1, err_seen[1], exp_err);
    start_frame(1'b0, 0);
    wait_done(3);

    // Out-of-range write in IDLE
    write_px(N, 1, 1'b1);
    tick();
    chk("err_count", 0, err_seen[0], exp_err);
    chk("err_count", 1, err_seen[1], exp_err);
    start_frame(1'b0, 0);
    wait_done(4);

    // Reset at beat 100, then a full replay of the retained frame
    start_frame(1'b0, 0);
    wait_beats(beats[0] + 100);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (4) tick();
    chk("no_done_after_rst", 0, done_cnt[0], 4);
    chk("no_done_after_rst", 1, done_cnt[1], 4);
    start_frame(1'b0, 0);
    wait_done(5);
    chk("err_count", 0, err_seen[0], exp_err);
    chk("err_count", 1, err_seen[1], exp_err);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
